// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcodes, command record and FSM states.
package alu_pkg;

    localparam int ALU_W     = 16;
    localparam int ALU_TAG_W = 4;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } alu_op_e;

    // op is a raw 3-bit field so that undefined opcodes pass through untouched
    typedef struct packed {
        logic [2:0]           op;
        logic [ALU_W-1:0]     a;
        logic [ALU_W-1:0]     b;
        logic                 use_acc;
        logic [ALU_TAG_W-1:0] tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO with wrap-bit pointers and a registered not-full flag.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  alu_cmd_t i_wdata,
    input  logic     i_pop,
    output alu_cmd_t o_rdata,
    output logic     o_full,
    output logic     o_empty,
    output logic     o_ready
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t       r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           r_ready;
    logic [AW:0]    w_wr_next;
    logic [AW:0]    w_rd_next;
    logic           w_push;
    logic           w_pop;
    logic           w_full_next;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign w_wr_next   = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_next   = r_rd_ptr + (AW+1)'(w_pop);
    assign w_full_next = (w_wr_next[AW] != w_rd_next[AW]) &&
                         (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_ready = r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            // ready is the not-full flag of the pointers that take effect this edge
            r_ready  <= !w_full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Issues queued commands to the combinational ALU and returns tagged results.
//   state | meaning
//   IDLE  | nothing in flight; pop the FIFO head when one is present
//   ISSUE | ALU operands stable; result captured at the end of the cycle
//   RESP  | response held until rsp_ready; then chain the next pop or go idle
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = ALU_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH:0]   alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    output logic             busy
);
    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_num1;
    logic [WIDTH-1:0] r_num2;
    logic [2:0]       r_sel;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp_valid;
    logic [WIDTH:0]   r_rsp_result;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_rsp_zero;

    alu_cmd_t         w_wdata;
    alu_cmd_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_load;
    logic             w_capture;
    logic             w_rsp_clr;

    assign w_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc, tag: cmd_tag};
    assign w_push  = cmd_valid && w_ready && !w_full;

    alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_load),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ready (w_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_rsp_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_capture    = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_clr = 1'b1;
                    if (!w_empty) begin
                        w_load       = 1'b1;
                        w_state_next = ISSUE;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_num1       <= '0;
            r_num2       <= '0;
            r_sel        <= '0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_load) begin
                // acc already holds the previous result: capture precedes the next pop
                r_num1 <= w_head.use_acc ? r_acc : w_head.a;
                r_num2 <= w_head.b;
                r_sel  <= w_head.op;
                r_tag  <= w_head.tag;
            end
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_result;
                r_rsp_tag    <= r_tag;
                r_rsp_zero   <= (alu_result[WIDTH-1:0] == '0);
                r_acc        <= alu_result[WIDTH-1:0];
            end else if (w_rsp_clr) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready  = w_ready;
    assign alu_num1   = r_num1;
    assign alu_num2   = r_num2;
    assign alu_sel    = r_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != IDLE) || !w_empty;

endmodule
